// File: rtl/npc_lsu_pkg.sv
// -----------------------------------------------------------------------------
// npc_lsu_pkg
// Shared types and helpers for the NPC load/store path.
//   size_t  : access size encoding (byte/half/word/dword)
//   state_t : lsu_mem_ctrl FSM states
//   size_mask()    : byte-enable pattern for a size at a lane offset (8 lanes)
//   addr_aligned() : natural-alignment check of the low address bits
// -----------------------------------------------------------------------------
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // ((1 << (1 << size)) - 1) << off, computed over 8 lanes; callers keep the
  // low DATA_W/8 bits. For a dword, 1<<8 wraps to 0 and the -1 gives 8'hFF.
  function automatic logic [7:0] size_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [7:0] m;
    m = (8'd1 << (4'd1 << size)) - 8'd1;
    return m << off;
  endfunction

  // True when addr mod 2^size == 0. For size 3, (1<<3) wraps to 0 in three
  // bits, so the mask becomes 3'b111 as required.
  function automatic logic addr_aligned(input logic [2:0] addr_lo,
                                        input logic [1:0] size);
    logic [2:0] m;
    m = (3'd1 << size) - 3'd1;
    return (addr_lo & m) == 3'd0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane alignment for stores and loads.
//   i_size     : access size (size_t encoding)
//   i_off      : byte offset of the access within the data bus
//   i_wdata    : right-aligned store data
//   i_rdata    : raw bus read data
//   i_unsigned : 1 = zero-extend load data, 0 = sign-extend
//   o_wmask    : byte enables for the store
//   o_wdata    : store data replicated across every lane of its size
//   o_rdata    : load data shifted down, truncated and extended to DATA_W
// -----------------------------------------------------------------------------
module lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                       i_size,
  input  logic [$clog2(DATA_W/8)-1:0]      i_off,
  input  logic [DATA_W-1:0]                i_wdata,
  input  logic [DATA_W-1:0]                i_rdata,
  input  logic                             i_unsigned,
  output logic [DATA_W/8-1:0]              o_wmask,
  output logic [DATA_W-1:0]                o_wdata,
  output logic [DATA_W-1:0]                o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DATA_W);

  logic [7:0]        w_mask8;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_low;
  logic [IDX_W-1:0]  w_sidx;
  logic              w_sign;

  always_comb begin
    w_mask8 = size_mask(i_size, 3'(i_off));
    o_wmask = w_mask8[NB-1:0];

    case (size_t'(i_size))
      SZ_B:    o_wdata = {NB{i_wdata[7:0]}};
      SZ_H:    o_wdata = {(NB/2){i_wdata[15:0]}};
      SZ_W:    o_wdata = {(NB/4){i_wdata[31:0]}};
      default: o_wdata = i_wdata;
    endcase

    // Bring the addressed bytes down to bit 0, then keep only the access
    // width and fill the rest with the sign bit (or zeros). A dword keeps
    // every bit, so extension never changes it.
    w_shift = i_rdata >> {i_off, 3'b000};
    case (size_t'(i_size))
      SZ_B: begin
        w_low  = DATA_W'(8'hFF);
        w_sidx = IDX_W'(7);
      end
      SZ_H: begin
        w_low  = DATA_W'(16'hFFFF);
        w_sidx = IDX_W'(15);
      end
      SZ_W: begin
        w_low  = DATA_W'(32'hFFFF_FFFF);
        w_sidx = IDX_W'(31);
      end
      default: begin
        w_low  = {DATA_W{1'b1}};
        w_sidx = IDX_W'(DATA_W - 1);
      end
    endcase
    w_sign  = !i_unsigned && w_shift[w_sidx];
    o_rdata = (w_shift & w_low) | ({DATA_W{w_sign}} & ~w_low);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Sequential load/store controller between the LSU stage and the memory bridge.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_*             : core request channel (valid/ready)
//   rsp_*             : core response channel (valid/ready)
//   mem_req/mem_gnt   : memory request handshake; mem_we/addr/wdata/wmask
//                       are held while mem_req waits for mem_gnt
//   mem_rvalid/rdata  : memory read return, any latency
//   dbg_state         : current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once raised, req_ready/rsp_valid/mem_req and their payloads stay
// stable until that transfer. req_ready is only high in IDLE, so a response
// and a new request are never exchanged in the same cycle.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl
  import npc_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state, w_next;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NB-1:0]       r_wmask;
  logic [1:0]          r_size;
  logic [OFF_W-1:0]    r_off;
  logic                r_unsigned;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_bad;
  logic                w_to;
  logic [1:0]          w_al_size;
  logic [OFF_W-1:0]    w_al_off;
  logic [NB-1:0]       w_al_wmask;
  logic [DATA_W-1:0]   w_al_wdata;
  logic [DATA_W-1:0]   w_al_rdata;

  // Misaligned, or dword on a 32-bit bus.
  assign w_bad = !addr_aligned(req_addr[2:0], req_size) ||
                 ((size_t'(req_size) == SZ_D) && (DATA_W != 64));

  assign w_to = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // One aligner serves both directions: in IDLE it sees the incoming store
  // fields (results captured on accept); in WAIT it sees the registered
  // size/offset against the returning bus data.
  assign w_al_size = (r_state == ST_IDLE) ? req_size : r_size;
  assign w_al_off  = (r_state == ST_IDLE) ? req_addr[OFF_W-1:0] : r_off;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_size     (w_al_size),
    .i_off      (w_al_off),
    .i_wdata    (req_wdata),
    .i_rdata    (mem_rdata),
    .i_unsigned (r_unsigned),
    .o_wmask    (w_al_wmask),
    .o_wdata    (w_al_wdata),
    .o_rdata    (w_al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_ready) begin
          w_accept = 1'b1;
          w_next   = w_bad ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: if (mem_gnt) w_next = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (mem_rvalid || w_to) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_size     <= '0;
      r_off      <= '0;
      r_unsigned <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // Registered so req_ready stays low through reset and rises on the
      // first edge after release; it is high exactly while in IDLE afterwards.
      r_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size     <= req_size;
            r_off      <= req_addr[OFF_W-1:0];
            r_unsigned <= req_unsigned;
            r_rdata    <= '0;
            r_err      <= w_bad;
            if (!w_bad) begin
              r_we    <= req_we;
              r_addr  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              r_wdata <= w_al_wdata;
              r_wmask <= w_al_wmask;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_rdata <= w_al_rdata;
            r_err   <= 1'b0;
          end else if (w_to) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mem_req   = (r_state == ST_ISSUE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl (ADDR_W=32, DATA_W=32, TIMEOUT=4).
// Inputs change 1ns after a rising edge; outputs are sampled at the same
// point, so a check after tick() observes the cycle that edge started.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; returns in cycle T+1.
  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic uns);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready got=%b exp=1", req_ready);
    end
    req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Load with gnt in the first ISSUE cycle and rvalid rv_dly cycles into WAIT.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int rv_dly,
                         input logic [31:0] rdata, input logic [31:0] exp,
                         input string name);
    start_req(1'b0, addr, 32'h0, size, uns);
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, addr & 32'hFFFF_FFFC}) begin
      bad++;
      $display("FAIL %s_issue got=%b/%b/%h exp=1/0/%h", name, mem_req, mem_we,
               mem_addr, addr & 32'hFFFF_FFFC);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      total++;
      if ({rsp_valid, mem_req} !== 2'b00) begin
        bad++;
        $display("FAIL %s_wait%0d got=%b%b exp=00", name, i, rsp_valid, mem_req);
      end
      mem_rdata = 32'hDEAD_BEEF;
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp}) begin
      bad++;
      $display("FAIL %s_rsp got=%b/%b/%h exp=1/0/%h", name, rsp_valid, rsp_err,
               rsp_rdata, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_idle got=%b%b exp=01", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; rsp_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, dbg_state} !== 7'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b%b%b%b%b st=%0d exp=0", req_ready, rsp_valid,
               rsp_err, mem_req, mem_we, dbg_state);
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wmask, rsp_rdata} !== 100'b0) begin
      bad++;
      $display("FAIL rst_data got=%h %h %h %h exp=0", mem_addr, mem_wdata,
               mem_wmask, rsp_rdata);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    total++;
    if ({req_ready, dbg_state} !== 3'b100) begin
      bad++;
      $display("FAIL rst_release got=%b st=%0d exp=1 st=0", req_ready, dbg_state);
    end
  endtask

  task automatic test_store_byte();
    start_req(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0);
    total++;
    if ({mem_req, mem_we, req_ready, rsp_valid} !== 4'b1100) begin
      bad++;
      $display("FAIL stb_ctrl got=%b%b%b%b exp=1100", mem_req, mem_we, req_ready,
               rsp_valid);
    end
    total++;
    if ({mem_addr, mem_wmask, mem_wdata} !== {32'h8000_0000, 4'b1000, 32'hABAB_ABAB}) begin
      bad++;
      $display("FAIL stb_mem got=%h/%b/%h exp=80000000/1000/abababab", mem_addr,
               mem_wmask, mem_wdata);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL stb_rsp got=%b%b%b/%h exp=100/0", rsp_valid, rsp_err,
               mem_req, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stb_idle got=%b%b exp=01", rsp_valid, req_ready);
    end
  endtask

  task automatic test_loads();
    do_load(32'h8000_0002, 2'd1, 1'b0, 2, 32'h8001_1234, 32'hFFFF_8001, "ldh_s");
    do_load(32'h8000_0002, 2'd1, 1'b1, 2, 32'h8001_1234, 32'h0000_8001, "ldh_u");
    do_load(32'h8000_0001, 2'd0, 1'b0, 0, 32'h0000_8000, 32'hFFFF_FF80, "ldb_s");
    do_load(32'h8000_0000, 2'd2, 1'b0, 1, 32'h8765_4321, 32'h8765_4321, "ldw");
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h8000_0001; sizes[0] = 2'd2;
    addrs[1] = 32'h8000_0003; sizes[1] = 2'd1;
    addrs[2] = 32'h8000_0008; sizes[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      start_req(1'b0, addrs[i], 32'h0, sizes[i], 1'b0);
      total++;
      if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {3'b110, 32'h0}) begin
        bad++;
        $display("FAIL err%0d_rsp got=%b%b%b/%h exp=110/0", i, rsp_valid,
                 rsp_err, mem_req, rsp_rdata);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      total++;
      if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
        bad++;
        $display("FAIL err%0d_idle got=%b%b%b exp=001", i, mem_req, rsp_valid,
                 req_ready);
      end
    end
  endtask

  task automatic test_stall();
    start_req(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({mem_req, mem_we, req_ready, rsp_valid, mem_addr} !==
          {4'b1000, 32'h8000_0004}) begin
        bad++;
        $display("FAIL stall_issue%0d got=%b%b%b%b/%h exp=1000/80000004", i,
                 mem_req, mem_we, req_ready, rsp_valid, mem_addr);
      end
      mem_gnt    = (i == 5);
      mem_rvalid = (i == 2);
      mem_rdata  = 32'hDEAD_BEEF;
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++;
    if ({mem_req, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL stall_wait got=%b%b exp=00", mem_req, rsp_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_err, req_ready, mem_req, rsp_rdata} !==
          {4'b1000, 32'hCAFE_F00D}) begin
        bad++;
        $display("FAIL stall_rsp%0d got=%b%b%b%b/%h exp=1000/cafef00d", i,
                 rsp_valid, rsp_err, req_ready, mem_req, rsp_rdata);
      end
      rsp_ready = (i == 4);
      tick();
    end
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stall_idle got=%b%b exp=01", rsp_valid, req_ready);
    end
  endtask

  task automatic test_timeout();
    start_req(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d got=%b exp=0", i, rsp_valid);
      end
      tick();
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      bad++;
      $display("FAIL to_rsp got=%b%b/%h exp=11/0", rsp_valid, rsp_err, rsp_rdata);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      bad++;
      $display("FAIL to_late got=%b%b/%h exp=11/0", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if ({rsp_valid, req_ready, dbg_state} !== 4'b0100) begin
      bad++;
      $display("FAIL to_no_second got=%b%b st=%0d exp=01 st=0", rsp_valid,
               req_ready, dbg_state);
    end
  endtask

  task automatic test_reset_in_wait();
    start_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, dbg_state} !== 7'b0 ||
        {mem_addr, mem_wmask, rsp_rdata} !== 68'b0) begin
      bad++;
      $display("FAIL rstw_out got=%b%b%b%b%b st=%0d %h %h exp=0", req_ready,
               rsp_valid, rsp_err, mem_req, mem_we, dbg_state, mem_addr, rsp_rdata);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rstw_release got=%b%b exp=10", req_ready, rsp_valid);
    end
    do_load(32'h8000_0010, 2'd2, 1'b0, 0, 32'h1122_3344, 32'h1122_3344, "rstw_ld");
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_stall();
    test_timeout();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Sequential, parametrised load/store memory controller for the NPC core; the successor to the combinational pmem access unit.
- Core side: valid/ready request and response channels.
- Memory side: req/gnt/rvalid port, any latency.
- Handles byte/half/word/dword sizing, lane alignment, write-mask generation, sign/zero extension, misalignment errors and a response timeout.
- Sits between the EXU/LSU stage and the memory/bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width; 32 or 64 only
TIMEOUT, 255, max WAIT cycles before error response; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  controller can accept request
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_size  in  2  0=byte 1=half 2=word 3=dword (3 legal only when DATA_W=64)
req_unsigned  in  1  load zero-extends when 1
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  DATA_W  extended load data; 0 for stores/errors
rsp_err  out  1  misaligned, illegal size or timeout
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request this cycle
mem_we  out  1  write enable
mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared
mem_wdata  out  DATA_W  lane-replicated store data
mem_wmask  out  DATA_W/8  byte enables
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  raw read data

Behaviour:
Reset
- Async reset, active-low, applies to all state.
- FSM resets to IDLE.
- All outputs reset to 0; req_ready=1 once in IDLE.
- Reset asserted mid-transaction abandons it; no response is produced.

FSM states and transitions
- IDLE:
  - req_ready=1; no other state asserts it.
  - On req_valid&&req_ready, register all request fields.
  - Misaligned (addr mod 2^size != 0) or illegal size: go to RESP with err=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1; mem_we/addr/wdata/wmask are registered and held stable until mem_gnt.
  - On gnt with store: go to RESP.
  - On gnt with load: go to WAIT and clear the timeout counter.
  - mem_rvalid in ISSUE is ignored.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture extracted data and go to RESP.
  - Otherwise the counter increments.
  - When counter==TIMEOUT-1 without rvalid, go to RESP with err=1 and rdata=0.
  - A late rvalid arriving after timeout is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE the next cycle. No back-to-back accept in the same cycle.

Latency (accept edge = T)
- Store, gnt in the first ISSUE cycle: mem_req high in cycle T+1; rsp_valid in cycle T+2.
- Load, gnt at T+1 and rvalid in cycle T+2: rsp_valid in cycle T+3.
- Error path: rsp_valid in cycle T+1; mem_req is never asserted.

Width rules
- off = addr[log2(DATA_W/8)-1:0].
- mem_wmask = ((1<<(1<<size))-1) << off.
- mem_wdata = low (8<<size) bits of req_wdata replicated across all lanes.
- Load data = mem_rdata >> (8*off), truncated to 8<<size bits, then sign- or zero-extended to DATA_W.
- Dword requests are zero-extension agnostic.

Decomposition:
Shared package npc_lsu_pkg holds:
- size enum SZ_B/SZ_H/SZ_W/SZ_D
- FSM state enum
- function for mask from size/offset
- alignment-check function

One sub-module, lsu_align:
- Purely combinational.
- Computes mem_wmask and mem_wdata from the store fields.
- Computes the extracted/extended load data.
- Reused by the future cache refill path.

Test Plan:
- Store byte, DATA_W=32, addr 0x8000_0003, wdata 0xAB, gnt immediately -> mem_addr 0x8000_0000, wmask 0b1000, wdata 0xABABABAB; rsp_valid at T+2, err=0.
- Signed half load at 0x8000_0002, mem_rdata 0x8001_1234, rvalid 3 cycles after gnt -> rsp_rdata 0xFFFF_8001. Same with req_unsigned=1 -> 0x0000_8001.
- Word load at 0x8000_0001 -> rsp_err=1 at T+1, mem_req never asserted, rsp_rdata 0.
- gnt held low 5 cycles, then rsp_ready held low 4 cycles -> mem_* stable throughout ISSUE, rsp_* stable throughout RESP, req_ready=0 until IDLE.
- TIMEOUT=4, load with no rvalid -> rsp_err=1 after 4 WAIT cycles. rvalid pulse afterwards -> no second response.
- rst_n dropped asynchronously in WAIT -> outputs 0 immediately. After release, a new word load 0x8000_0010 completes normally.
